// File: rtl/rr_arbiter_4_pkg.sv
// Shared constants, state encoding and helpers for the four-way round-robin arbiter.
// Imported by the top level and by the priority picker.
package rr_arbiter_4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin pick: rotate requests so last+1 comes first,
// priority-encode the lowest rotated position, then map back to a requester index.
module rr_prio_pick
  import rr_arbiter_4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any
);

  logic [IDX_W-1:0]   src_idx [NUM_REQ];
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   pick;

  // Rotated slot gi looks at requester (last + 1 + gi) mod 4; the wrap comes
  // for free from the 2-bit adder.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign src_idx[gi] = last + IDX_W'(gi + 1);
      assign rot[gi]     = req[src_idx[gi]];
    end
  endgenerate

  always_comb begin
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pick = IDX_W'(k);
      end
    end
  end

  assign any        = |req;
  assign winner_idx = any ? src_idx[pick] : '0;
  assign winner     = any ? idx_to_onehot(winner_idx) : '0;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant hold, forced release after
// MAX_HOLD cycles, and a mandatory idle cycle between consecutive grants.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_valid,
  output logic                timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               valid_reg, valid_next;
  logic               timeout_reg, timeout_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   last_reg, last_next;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_prio_pick u_pick (
    .req        (req),
    .last       (last_reg),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= '0;
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      cnt_reg     <= '0;
      last_reg    <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      idx_reg     <= idx_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
      cnt_reg     <= cnt_next;
      last_reg    <= last_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    idx_next     = idx_reg;
    valid_next   = valid_reg;
    timeout_next = 1'b0;
    cnt_next     = cnt_reg;
    last_next    = last_reg;

    case (state_reg)
      ST_IDLE: begin
        if (pick_any) begin
          state_next = ST_GRANT;
          grant_next = pick_onehot;
          idx_next   = pick_idx;
          valid_next = 1'b1;
          cnt_next   = '0;
          last_next  = pick_idx;
        end
      end
      ST_GRANT: begin
        // Release is checked first so a release coinciding with the hold
        // limit never raises timeout.
        if (!req[idx_reg]) begin
          state_next = ST_IDLE;
          grant_next = '0;
          idx_next   = '0;
          valid_next = 1'b0;
          cnt_next   = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next   = ST_IDLE;
          grant_next   = '0;
          idx_next     = '0;
          valid_next   = 1'b0;
          cnt_next     = '0;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
        idx_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  assign grant       = grant_reg;
  assign grant_idx   = idx_reg;
  assign grant_valid = valid_reg;
  assign timeout     = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: grant order, hold, timeout, release priority
// and asynchronous reset, with hand-computed expectations.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  rr_arbiter_4 #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                            input logic to);
    check({tag, ".grant"}, {4'b0, grant}, {4'b0, g});
    check({tag, ".idx"}, {6'b0, grant_idx}, {6'b0, idx});
    check({tag, ".valid"}, {7'b0, grant_valid}, {7'b0, |g});
    check({tag, ".timeout"}, {7'b0, timeout}, {7'b0, to});
    $display("step %-16s req=%b grant=%b idx=%0d valid=%b timeout=%b", tag, req, grant,
             grant_idx, grant_valid, timeout);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] exp_g;

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    expect_out("reset", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;

    // Single requester: one-cycle latency, drop the cycle after release.
    req = 4'b0001;
    step();
    expect_out("single_grant", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    step();
    expect_out("single_release", 4'b0000, 2'd0, 1'b0);

    // All request; each holds two granted cycles then drops, rotation from last=3.
    do_reset();
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      expect_out("rr_grant", exp_g, 2'(k % 4), 1'b0);
      step();
      expect_out("rr_hold", exp_g, 2'(k % 4), 1'b0);
      req = 4'b1111 & ~exp_g;
      step();
      expect_out("rr_idle", 4'b0000, 2'd0, 1'b0);
      req = 4'b1111;
      step();
    end
    req = 4'b0000;
    step();
    step();

    // last=1, then 0 and 1 both requesting: 0 comes first in rotation.
    do_reset();
    req = 4'b0010;
    step();
    expect_out("last1_grant", 4'b0010, 2'd1, 1'b0);
    req = 4'b0001;
    step();
    expect_out("last1_release", 4'b0000, 2'd0, 1'b0);
    req = 4'b0011;
    step();
    expect_out("rot_0_beats_1", 4'b0001, 2'd0, 1'b0);
    req = 4'b0010;
    step();
    expect_out("rot_release0", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("rot_then_1", 4'b0010, 2'd1, 1'b0);
    req = 4'b0000;
    step();

    // Requesters 0 and 2 hold forever: alternate by timeout.
    do_reset();
    req = 4'b0101;
    step();
    for (int k = 0; k < 8; k++) begin
      expect_out("hold_0", 4'b0001, 2'd0, 1'b0);
      if (k < 7) step();
    end
    step();
    expect_out("timeout_0", 4'b0000, 2'd0, 1'b1);
    step();
    for (int k = 0; k < 8; k++) begin
      expect_out("hold_2", 4'b0100, 2'd2, 1'b0);
      if (k < 7) step();
    end
    step();
    expect_out("timeout_2", 4'b0000, 2'd0, 1'b1);
    step();
    expect_out("back_to_0", 4'b0001, 2'd0, 1'b0);

    // Release on exactly the cycle the hold limit is reached: no timeout.
    for (int k = 0; k < 7; k++) step();
    expect_out("at_limit", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    step();
    expect_out("release_at_limit", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("release_idle", 4'b0000, 2'd0, 1'b0);

    // Glitch on a non-granted line during a grant has no effect.
    req = 4'b0010;
    step();
    expect_out("grant_1", 4'b0010, 2'd1, 1'b0);
    req = 4'b0011;
    step();
    req = 4'b1010;
    step();
    expect_out("glitch_ignored", 4'b0010, 2'd1, 1'b0);
    req = 4'b0010;

    // Asynchronous reset between edges clears outputs at once and restores last=3.
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 4'b0000, 2'd0, 1'b0);
    req = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    expect_out("after_reset_pick0", 4'b0001, 2'd0, 1'b0);
    req = 4'b1000;
    step();
    expect_out("after_reset_rel", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("after_reset_g3", 4'b1000, 2'd3, 1'b0);
    req = 4'b0000;
    step();
    expect_out("final_idle", 4'b0000, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
